// File: rtl/sweep_pkg.sv
// Shared types for the mux operand sweeper.
// State encoding is fixed so lab tooling can decode it.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/sweep_counter.sv
// Up-counter with enable, synchronous clear
// and terminal-count flag.
module sweep_counter #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + 1'b1;
    end
  end

  assign tc = &q;

endmodule

// File: rtl/mux_operand_sweeper.sv
// Sweeps {Select, In_1, In_0} through every combination
// with programmable dwell and pause for mux bring-up.
module mux_operand_sweeper
  import sweep_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DWELL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] In_1,
  output logic [WIDTH-1:0] In_0,
  output logic             Select,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = 2 * WIDTH + 1;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL - 1);

  state_e        state;
  logic [DW-1:0] dwell;
  logic [CW-1:0] idx;
  logic          tc;
  logic          dwell_last;
  logic          adv;
  logic          cnt_en;
  logic          cnt_clr;

  assign dwell_last = (dwell == DWELL_MAX);
  assign adv        = (state == RUN) && !pause && dwell_last;
  assign cnt_en     = adv && !tc;
  // Clearing on the final advance leaves operands at 0 in DONE.
  assign cnt_clr    = reset || (adv && tc);

  sweep_counter #(
    .W (CW)
  ) u_cnt (
    .clk (clk),
    .clr (cnt_clr),
    .en  (cnt_en),
    .q   (idx),
    .tc  (tc)
  );

  assign Select = idx[CW-1];
  assign In_1   = idx[2*WIDTH-1:WIDTH];
  assign In_0   = idx[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      dwell <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            valid <= 1'b1;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!pause) begin
            if (dwell_last) begin
              dwell <= '0;
              if (tc) begin
                state <= DONE;
                valid <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              dwell <= dwell + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          dwell <= '0;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
